bus_bridge_arb: RTL

//  CPU-to-peripheral system bridge, successor to the fixed DM/TC0/TC1 decoder. Sits between the
//  M-stage memory port and NUM_SLAVES memory-mapped slaves (DM, timers, future UART/switch/LED).

---
 rtl/bus_bridge_arb_pkg.sv | 31 +++
 rtl/bus_bridge_arb_addr_decode.sv | 39 +++
 rtl/bus_bridge_arb.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/bus_bridge_arb_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge: FSM state encoding and
// the default slave memory map (DM, TC0, TC1).
package bus_bridge_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } bridge_state_t;

  localparam int DEFAULT_NUM_SLAVES = 3;

  localparam logic [31:0] DM_BASE   = 32'h0000_0000;
  localparam logic [31:0] DM_LIMIT  = 32'h0000_2fff;
  localparam logic [31:0] TC0_BASE  = 32'h0000_7f00;
  localparam logic [31:0] TC0_LIMIT = 32'h0000_7f0b;
  localparam logic [31:0] TC1_BASE  = 32'h0000_7f10;
  localparam logic [31:0] TC1_LIMIT = 32'h0000_7f1b;

  localparam logic [95:0] DEFAULT_BASE_ADDRS  = {TC1_BASE, TC0_BASE, DM_BASE};
  localparam logic [95:0] DEFAULT_LIMIT_ADDRS = {TC1_LIMIT, TC0_LIMIT, DM_LIMIT};
  localparam logic [2:0]  DEFAULT_RO_MASK     = 3'b000;
  localparam int          DEFAULT_TIMEOUT     = 16;

  // Width of a slave index; a single-slave bridge still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_bridge_arb_addr_decode.sv
// Combinational address decoder: maps a byte address onto the slave windows,
// lowest index wins on overlap, and reports whether the winner is read-only.
module bridge_addr_decode
  import bus_bridge_arb_pkg::*;
#(
  parameter int                         NUM_SLAVES  = DEFAULT_NUM_SLAVES,
  parameter logic [NUM_SLAVES*32-1:0]   BASE_ADDRS  = DEFAULT_BASE_ADDRS,
  parameter logic [NUM_SLAVES*32-1:0]   LIMIT_ADDRS = DEFAULT_LIMIT_ADDRS,
  parameter logic [NUM_SLAVES-1:0]      RO_MASK     = DEFAULT_RO_MASK,
  parameter int                         IW          = idx_width(NUM_SLAVES)
) (
  input  logic [31:0]   addr,
  output logic [IW-1:0] idx,
  output logic          any_hit,
  output logic          ro
);

  logic [NUM_SLAVES-1:0] hit;

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_win
    assign hit[gi] = (addr >= BASE_ADDRS[32*gi +: 32]) &&
                     (addr <= LIMIT_ADDRS[32*gi +: 32]);
  end

  assign any_hit = |hit;

  // Scan from the top so the lowest matching window is the last to overwrite.
  always_comb begin
    idx = '0;
    ro  = 1'b0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (hit[i]) begin
        idx = IW'(i);
        ro  = RO_MASK[i];
      end
    end
  end

endmodule

// File: rtl/bus_bridge_arb.sv
// CPU-to-peripheral bridge: windowed decode, variable-latency slave handshake
// with timeout, error reporting and a registered read-data return.
module bus_bridge_arb
  import bus_bridge_arb_pkg::*;
#(
  parameter int                         NUM_SLAVES  = DEFAULT_NUM_SLAVES,
  parameter logic [NUM_SLAVES*32-1:0]   BASE_ADDRS  = DEFAULT_BASE_ADDRS,
  parameter logic [NUM_SLAVES*32-1:0]   LIMIT_ADDRS = DEFAULT_LIMIT_ADDRS,
  parameter logic [NUM_SLAVES-1:0]      RO_MASK     = DEFAULT_RO_MASK,
  parameter int                         TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_req,
  input  logic [31:0]                cpu_addr,
  input  logic [3:0]                 cpu_byteen,
  input  logic [31:0]                cpu_wdata,
  output logic [31:0]                cpu_rdata,
  output logic                       cpu_ready,
  output logic                       cpu_err,
  output logic [NUM_SLAVES-1:0]      sl_sel,
  output logic [NUM_SLAVES-1:0]      sl_we,
  output logic [31:0]                sl_addr,
  output logic [3:0]                 sl_byteen,
  output logic [31:0]                sl_wdata,
  input  logic [NUM_SLAVES*32-1:0]   sl_rdata,
  input  logic [NUM_SLAVES-1:0]      sl_ready
);

  localparam int IW = idx_width(NUM_SLAVES);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT - 1);

  bridge_state_t         state_reg;
  logic [CW-1:0]         count_reg;
  logic [31:0]           rdata_reg;
  logic                  ready_reg;
  logic                  err_reg;
  logic [NUM_SLAVES-1:0] sel_reg;
  logic [NUM_SLAVES-1:0] we_reg;
  logic [31:0]           addr_reg;
  logic [3:0]            byteen_reg;
  logic [31:0]           wdata_reg;

  logic [IW-1:0]         dec_idx;
  logic                  dec_any_hit;
  logic                  dec_ro;
  logic [NUM_SLAVES-1:0] dec_onehot;
  logic                  req_write;
  logic                  sel_ready;
  logic [31:0]           sel_rdata;

  bridge_addr_decode #(
    .NUM_SLAVES  (NUM_SLAVES),
    .BASE_ADDRS  (BASE_ADDRS),
    .LIMIT_ADDRS (LIMIT_ADDRS),
    .RO_MASK     (RO_MASK),
    .IW          (IW)
  ) u_decode (
    .addr    (cpu_addr),
    .idx     (dec_idx),
    .any_hit (dec_any_hit),
    .ro      (dec_ro)
  );

  assign dec_onehot = NUM_SLAVES'(1) << dec_idx;
  assign req_write  = |cpu_byteen;

  // Handshake and data return only ever look at the latched, selected slave.
  assign sel_ready = |(sl_ready & sel_reg);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_reg[i]) begin
        sel_rdata = sel_rdata | sl_rdata[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      rdata_reg  <= '0;
      ready_reg  <= 1'b0;
      err_reg    <= 1'b0;
      sel_reg    <= '0;
      we_reg     <= '0;
      addr_reg   <= '0;
      byteen_reg <= '0;
      wdata_reg  <= '0;
    end else begin
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cpu_req) begin
            if (!dec_any_hit || (dec_ro && req_write)) begin
              ready_reg <= 1'b1;
              err_reg   <= 1'b1;
              rdata_reg <= '0;
              state_reg <= ST_ERR;
            end else begin
              addr_reg   <= cpu_addr;
              byteen_reg <= cpu_byteen;
              wdata_reg  <= cpu_wdata;
              sel_reg    <= dec_onehot;
              we_reg     <= req_write ? dec_onehot : '0;
              count_reg  <= '0;
              state_reg  <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // A ready in the last counted cycle still completes normally.
          if (sel_ready) begin
            rdata_reg <= (|byteen_reg) ? 32'h0 : sel_rdata;
            sel_reg   <= '0;
            we_reg    <= '0;
            ready_reg <= 1'b1;
            state_reg <= ST_RESP;
          end else if (count_reg == COUNT_LAST) begin
            sel_reg   <= '0;
            we_reg    <= '0;
            ready_reg <= 1'b1;
            err_reg   <= 1'b1;
            rdata_reg <= '0;
            state_reg <= ST_ERR;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
        ST_RESP: state_reg <= ST_IDLE;
        ST_ERR:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cpu_rdata = rdata_reg;
  assign cpu_ready = ready_reg;
  assign cpu_err   = err_reg;
  assign sl_sel    = sel_reg;
  assign sl_we     = we_reg;
  assign sl_addr   = addr_reg;
  assign sl_byteen = byteen_reg;
  assign sl_wdata  = wdata_reg;

endmodule
